// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache between the core and a word-addressed memory.
// Latency: load hit 0 cycles (combinational); load miss LINE_WORDS+1 cycles minimum; store 1 cycle + ack wait.
// Backpressure: core_ready low stalls the core; mem_req and its fields are held stable until mem_ack.

module data_cache #(
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_LINES  = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [31:0]           core_wdata,
    input  logic [3:0]            core_wstrb,
    output logic [31:0]           core_rdata,
    output logic                  core_ready,
    input  logic                  invalidate,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ack,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
);

    // Word-select width is kept at least 1 so a single-word line still has a legal counter.
    localparam int WSEL_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int OFF_W  = $clog2(LINE_WORDS) + 2;
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = ADDR_WIDTH - OFF_W - IDX_W;
    localparam int DA_W   = IDX_W + WSEL_W;

    localparam logic [WSEL_W-1:0]     LAST_K    = WSEL_W'(LINE_WORDS - 1);
    localparam logic [WSEL_W-1:0]     WSEL_MASK = WSEL_W'(LINE_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'((1 << OFF_W) - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE
    } state_t;

    state_t state;

    logic [WSEL_W-1:0]    fill_k;
    logic                 inv_pending;
    logic                 refilled;
    logic [NUM_LINES-1:0] valid;
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [31:0]          data_mem [1 << DA_W];

    logic [IDX_W-1:0]      idx;
    logic [TAG_W-1:0]      tag;
    logic [WSEL_W-1:0]     wsel;
    logic                  hit;
    logic                  inval_now;
    logic                  load_hit;
    logic [31:0]           rd_word;
    logic [31:0]           merged;
    logic [ADDR_WIDTH-1:0] fill_addr;

    assign idx       = IDX_W'(core_addr >> OFF_W);
    assign tag       = TAG_W'(core_addr >> (OFF_W + IDX_W));
    assign wsel      = WSEL_W'(core_addr[ADDR_WIDTH-1:2]) & WSEL_MASK;
    assign hit       = valid[idx] && (tag_mem[idx] == tag);
    // A pending invalidate from FILL/WRITE is applied on the first IDLE cycle, like a live one.
    assign inval_now = (state == IDLE) && (invalidate || inv_pending);
    assign load_hit  = (state == IDLE) && core_req && !core_we && hit && !inval_now;
    assign rd_word   = data_mem[{idx, wsel}];
    assign fill_addr = (core_addr & LINE_MASK) | ADDR_WIDTH'({fill_k, 2'b00});

    assign core_rdata = load_hit ? rd_word : 32'h0;
    assign core_ready = load_hit || ((state == WRITE) && core_req && mem_ack);
    assign mem_req    = (state != IDLE);
    assign mem_we     = (state == WRITE);
    assign mem_addr   = (state == WRITE) ? {core_addr[ADDR_WIDTH-1:2], 2'b00} : fill_addr;
    assign mem_wdata  = core_wdata;
    assign mem_wstrb  = (state == WRITE) ? core_wstrb : 4'h0;

    // Byte-merge of the store data over the currently cached word for write hits.
    always_comb begin
        merged = rd_word;
        for (int b = 0; b < 4; b++) begin
            if (core_wstrb[b]) merged[8*b +: 8] = core_wdata[8*b +: 8];
        end
    end

    // Control FSM, valid bits and saturating counters; reset aborts any memory transfer at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            fill_k      <= '0;
            valid       <= '0;
            inv_pending <= 1'b0;
            refilled    <= 1'b0;
            hit_count   <= '0;
            miss_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    inv_pending <= 1'b0;
                    refilled    <= 1'b0;
                    if (inval_now) valid <= '0;
                    if (core_req) begin
                        if (core_we) begin
                            state <= WRITE;
                        end else if (load_hit) begin
                            // The load that caused a refill retires here without counting as a hit.
                            if (!refilled && (hit_count != '1)) hit_count <= hit_count + 32'd1;
                        end else begin
                            if (miss_count != '1) miss_count <= miss_count + 32'd1;
                            valid[idx] <= 1'b0;
                            fill_k     <= '0;
                            state      <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (invalidate) inv_pending <= 1'b1;
                    if (mem_ack) begin
                        if (fill_k == LAST_K) begin
                            valid[idx] <= 1'b1;
                            refilled   <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            fill_k <= fill_k + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (invalidate) inv_pending <= 1'b1;
                    if (mem_ack) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Line storage: fill words from memory, write tag on the last word, merge store bytes on write hits.
    always_ff @(posedge clk) begin
        if ((state == FILL) && mem_ack) begin
            data_mem[{idx, fill_k}] <= mem_rdata;
            if (fill_k == LAST_K) tag_mem[idx] <= tag;
        end
        if ((state == WRITE) && mem_ack && hit) begin
            data_mem[{idx, wsel}] <= merged;
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed scenarios plus randomized loads/stores.
// Reference: resident-line table per index and a flat word memory (write-through keeps them coherent).
// Memory responder acks with a fixed or random wait and logs every accepted transfer.

module tb_data_cache;

    localparam int NL = 16;
    localparam int LW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        core_req, core_we, invalidate;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic [3:0]  core_wstrb;
    logic        core_ready;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] hit_count, miss_count;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } txn_t;

    txn_t        txq[$];
    logic [31:0] mem_model [logic [31:0]];
    int          ack_delay = 0;
    logic        spurious_ack = 1'b0;
    logic        resp_ack = 1'b0;
    bit          resp_busy = 1'b0;
    int          resp_wl = 0;

    bit          ref_valid [NL];
    logic [31:0] ref_base  [NL];
    int          ref_hits = 0;
    int          ref_misses = 0;

    assign mem_ack = resp_ack | spurious_ack;

    always #5 clk = ~clk;

    data_cache #(.ADDR_WIDTH(32), .NUM_LINES(NL), .LINE_WORDS(LW)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_wstrb(core_wstrb),
        .core_rdata(core_rdata), .core_ready(core_ready),
        .invalidate(invalidate),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (mem_model.exists(w)) return mem_model[w];
        return w ^ 32'hC0DE_0000;
    endfunction

    function automatic int line_idx(input logic [31:0] a);
        return int'((a >> 4) & 32'(NL - 1));
    endfunction

    task automatic model_load(input logic [31:0] a, output bit was_hit);
        int i;
        i = line_idx(a);
        was_hit = ref_valid[i] && (ref_base[i] == (a & ~32'hF));
        if (was_hit) ref_hits++;
        else begin
            ref_misses++;
            ref_valid[i] = 1'b1;
            ref_base[i]  = a & ~32'hF;
        end
    endtask

    task automatic model_invalidate();
        for (int i = 0; i < NL; i++) ref_valid[i] = 1'b0;
    endtask

    // Backing memory: acks after ack_delay wait cycles (random 0..2 when negative).
    initial begin
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!mem_req) begin
                resp_busy = 1'b0;
                resp_ack  = 1'b0;
            end else begin
                if (!resp_busy) begin
                    resp_busy = 1'b1;
                    resp_wl   = (ack_delay < 0) ? int'($urandom_range(0, 2)) : ack_delay;
                end
                if (resp_wl == 0) begin
                    txn_t t;
                    logic [31:0] w;
                    resp_ack  = 1'b1;
                    resp_busy = 1'b0;
                    mem_rdata = mem_read(mem_addr);
                    t.we = mem_we; t.addr = mem_addr; t.wdata = mem_wdata; t.wstrb = mem_wstrb;
                    txq.push_back(t);
                    if (mem_we) begin
                        w = mem_read(mem_addr);
                        for (int b = 0; b < 4; b++)
                            if (mem_wstrb[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
                        mem_model[{mem_addr[31:2], 2'b00}] = w;
                    end
                end else begin
                    resp_ack = 1'b0;
                    resp_wl--;
                end
            end
        end
    end

    // One core access, entered and left at posedge+1; cyc is the cycle index of core_ready.
    task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] wstrb, input int inv_at,
                             output logic [31:0] rdata, output int cyc, output int reqcyc);
        txq.delete();
        core_req = 1'b1; core_we = we; core_addr = addr; core_wdata = wdata; core_wstrb = wstrb;
        invalidate = (inv_at == 0);
        cyc = -1; reqcyc = 0; rdata = '0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (mem_req) reqcyc++;
            if (core_ready) begin
                cyc = c;
                rdata = core_rdata;
                break;
            end
            @(posedge clk);
            #1;
            invalidate = (c + 1 == inv_at);
        end
        @(posedge clk);
        #1;
        core_req = 1'b0; core_we = 1'b0; invalidate = 1'b0;
        if (cyc < 0) begin
            total++;
            $display("FAIL access_timeout addr=%h: no core_ready, required within 400 cycles", addr);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (core_ready !== 1'b0) $display("FAIL reset_ready got %b exp 0", core_ready); else passed++;
        total++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req got %b exp 0", mem_req); else passed++;
        total++; if (hit_count !== 32'd0) $display("FAIL reset_hits got %0d exp 0", hit_count); else passed++;
        total++; if (miss_count !== 32'd0) $display("FAIL reset_misses got %0d exp 0", miss_count); else passed++;
        total++; if (core_rdata !== 32'd0) $display("FAIL reset_rdata got %h exp 0", core_rdata); else passed++;
        rst = 1'b1;
        model_invalidate(); ref_hits = 0; ref_misses = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_first_miss();
        logic [31:0] rd; int cyc, rq; bit h;
        ack_delay = 0;
        model_load(32'h100, h);
        do_access(1'b0, 32'h100, 32'h0, 4'h0, -1, rd, cyc, rq);
        total++; if (txq.size() != LW) $display("FAIL fill_count got %0d exp %0d", txq.size(), LW); else passed++;
        for (int i = 0; i < LW && i < txq.size(); i++) begin
            total++;
            if (txq[i].we !== 1'b0 || txq[i].addr !== 32'h100 + 32'(4 * i))
                $display("FAIL fill_addr[%0d] got we=%b addr=%h exp we=0 addr=%h", i, txq[i].we, txq[i].addr, 32'h100 + 32'(4 * i));
            else passed++;
        end
        total++; if (cyc != 5) $display("FAIL miss_latency got %0d exp 5", cyc); else passed++;
        total++; if (rd !== 32'hA0) $display("FAIL miss_rdata got %h exp 000000a0", rd); else passed++;
        total++; if (miss_count !== 32'(ref_misses)) $display("FAIL miss_count1 got %0d exp %0d", miss_count, ref_misses); else passed++;
        total++; if (hit_count !== 32'(ref_hits)) $display("FAIL refill_no_hit got %0d exp %0d", hit_count, ref_hits); else passed++;
    endtask

    task automatic test_hit();
        logic [31:0] rd; int cyc, rq; bit h;
        model_load(32'h108, h);
        do_access(1'b0, 32'h108, 32'h0, 4'h0, -1, rd, cyc, rq);
        total++; if (cyc != 0) $display("FAIL hit_latency got %0d exp 0", cyc); else passed++;
        total++; if (rd !== 32'hA2) $display("FAIL hit_rdata got %h exp 000000a2", rd); else passed++;
        total++; if (rq != 0 || txq.size() != 0) $display("FAIL hit_no_mem got req_cycles=%0d txns=%0d exp 0", rq, txq.size()); else passed++;
        total++; if (hit_count !== 32'(ref_hits)) $display("FAIL hit_count got %0d exp %0d", hit_count, ref_hits); else passed++;
    endtask

    task automatic test_store_hit();
        logic [31:0] rd; int cyc, rq; bit h;
        ack_delay = 2;
        do_access(1'b1, 32'h104, 32'h1122_3344, 4'b0011, -1, rd, cyc, rq);
        total++; if (rq != 3) $display("FAIL store_req_cycles got %0d exp 3", rq); else passed++;
        total++; if (cyc != 3) $display("FAIL store_latency got %0d exp 3", cyc); else passed++;
        total++;
        if (txq.size() != 1 || txq[0].we !== 1'b1 || txq[0].addr !== 32'h104 || txq[0].wdata !== 32'h1122_3344 || txq[0].wstrb !== 4'b0011)
            $display("FAIL store_txn got n=%0d we=%b addr=%h data=%h strb=%b exp n=1 we=1 addr=104 data=11223344 strb=0011",
                     txq.size(), txq[0].we, txq[0].addr, txq[0].wdata, txq[0].wstrb);
        else passed++;
        total++; if (hit_count !== 32'(ref_hits)) $display("FAIL store_no_hit got %0d exp %0d", hit_count, ref_hits); else passed++;
        ack_delay = 0;
        model_load(32'h104, h);
        do_access(1'b0, 32'h104, 32'h0, 4'h0, -1, rd, cyc, rq);
        total++; if (cyc != 0) $display("FAIL merged_hit_latency got %0d exp 0", cyc); else passed++;
        total++; if (rd !== 32'h0000_3344) $display("FAIL merged_rdata got %h exp 00003344", rd); else passed++;
    endtask

    task automatic test_store_miss();
        logic [31:0] rd, wd; int cyc, rq; bit h;
        ack_delay = 1;
        wd = $urandom;
        do_access(1'b1, 32'h400, wd, 4'hF, -1, rd, cyc, rq);
        total++; if (cyc != 2) $display("FAIL store_miss_latency got %0d exp 2", cyc); else passed++;
        model_load(32'h400, h);
        do_access(1'b0, 32'h400, 32'h0, 4'h0, -1, rd, cyc, rq);
        total++; if (h || cyc != 4 * 2 + 1) $display("FAIL no_allocate got latency %0d exp %0d", cyc, 4 * 2 + 1); else passed++;
        total++; if (txq.size() == 0 || txq[0].addr !== 32'h400) $display("FAIL store_miss_fill got n=%0d exp first addr 400", txq.size()); else passed++;
        total++; if (rd !== wd) $display("FAIL store_miss_rdata got %h exp %h", rd, wd); else passed++;
        total++; if (miss_count !== 32'(ref_misses)) $display("FAIL store_miss_count got %0d exp %0d", miss_count, ref_misses); else passed++;
    endtask

    task automatic test_conflict();
        logic [31:0] rd; int cyc, rq; bit h;
        logic [31:0] seq [3];
        ack_delay = 0;
        seq[0] = 32'h100; seq[1] = 32'h100 + NL * LW * 4; seq[2] = 32'h100;
        for (int i = 0; i < 3; i++) begin
            model_load(seq[i], h);
            do_access(1'b0, seq[i], 32'h0, 4'h0, -1, rd, cyc, rq);
            total++; if (cyc != (h ? 0 : 5)) $display("FAIL conflict_latency[%0d] got %0d exp %0d", i, cyc, h ? 0 : 5); else passed++;
            total++; if (rd !== mem_read(seq[i])) $display("FAIL conflict_rdata[%0d] got %h exp %h", i, rd, mem_read(seq[i])); else passed++;
        end
        total++; if (miss_count !== 32'(ref_misses)) $display("FAIL conflict_misses got %0d exp %0d", miss_count, ref_misses); else passed++;
    endtask

    task automatic test_reset_midfill();
        logic [31:0] rd; int cyc, rq; bit h; bit got2;
        ack_delay = 0;
        model_load(32'h200, h);
        do_access(1'b0, 32'h200, 32'h0, 4'h0, -1, rd, cyc, rq);
        txq.delete();
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h100;
        got2 = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (txq.size() >= 2) begin got2 = 1'b1; break; end
        end
        total++; if (!got2) $display("FAIL midfill_acks got %0d exp 2", txq.size()); else passed++;
        rst = 1'b0; core_req = 1'b0;
        #1;
        total++; if (mem_req !== 1'b0) $display("FAIL reset_drops_req got %b exp 0", mem_req); else passed++;
        total++; if (miss_count !== 32'd0 || hit_count !== 32'd0) $display("FAIL reset_counters got %0d/%0d exp 0/0", hit_count, miss_count); else passed++;
        model_invalidate(); ref_hits = 0; ref_misses = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_load(32'h100, h);
        do_access(1'b0, 32'h100, 32'h0, 4'h0, -1, rd, cyc, rq);
        total++; if (txq.size() != LW || txq[0].addr !== 32'h100) $display("FAIL restart_fill got n=%0d addr=%h exp n=4 addr=100", txq.size(), txq[0].addr); else passed++;
        total++; if (cyc != 5 || rd !== 32'hA0) $display("FAIL restart_load got cyc=%0d rd=%h exp cyc=5 rd=a0", cyc, rd); else passed++;
        total++; if (miss_count !== 32'd1) $display("FAIL restart_misses got %0d exp 1", miss_count); else passed++;
    endtask

    task automatic test_invalidate();
        logic [31:0] rd; int cyc, rq; bit h;
        invalidate = 1'b1;
        @(posedge clk);
        #1;
        invalidate = 1'b0;
        model_invalidate();
        model_load(32'h108, h);
        do_access(1'b0, 32'h108, 32'h0, 4'h0, -1, rd, cyc, rq);
        total++; if (cyc != 5 || txq.size() != LW) $display("FAIL inval_miss got cyc=%0d n=%0d exp cyc=5 n=4", cyc, txq.size()); else passed++;
        total++; if (txq[0].addr !== 32'h100) $display("FAIL inval_fill_start got %h exp 100", txq[0].addr); else passed++;
        total++; if (rd !== 32'hA2) $display("FAIL inval_rdata got %h exp a2", rd); else passed++;
        total++; if (miss_count !== 32'(ref_misses)) $display("FAIL inval_misses got %0d exp %0d", miss_count, ref_misses); else passed++;
    endtask

    task automatic test_inv_with_req();
        logic [31:0] rd; int cyc, rq; bit h;
        ack_delay = 0;
        model_invalidate();
        model_load(32'h104, h);
        do_access(1'b0, 32'h104, 32'h0, 4'h0, 0, rd, cyc, rq);
        total++; if (cyc != 5 || rd !== mem_read(32'h104)) $display("FAIL inv_req_miss got cyc=%0d rd=%h exp cyc=5 rd=%h", cyc, rd, mem_read(32'h104)); else passed++;
        total++; if (hit_count !== 32'(ref_hits)) $display("FAIL inv_req_no_hit got %0d exp %0d", hit_count, ref_hits); else passed++;
        model_load(32'h300, h);
        model_invalidate();
        model_load(32'h300, h);
        do_access(1'b0, 32'h300, 32'h0, 4'h0, 2, rd, cyc, rq);
        total++; if (txq.size() != 2 * LW || cyc != 10) $display("FAIL inv_during_fill got n=%0d cyc=%0d exp n=8 cyc=10", txq.size(), cyc); else passed++;
        total++; if (rd !== mem_read(32'h300)) $display("FAIL inv_during_fill_rdata got %h exp %h", rd, mem_read(32'h300)); else passed++;
        total++; if (hit_count !== 32'(ref_hits)) $display("FAIL inv_fill_no_hit got %0d exp %0d", hit_count, ref_hits); else passed++;
    endtask

    task automatic test_spurious_ack();
        logic [31:0] rd; int cyc, rq; bit h;
        spurious_ack = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++; if (mem_req !== 1'b0 || core_ready !== 1'b0) $display("FAIL spurious_ack[%0d] got req=%b ready=%b exp 0/0", c, mem_req, core_ready); else passed++;
        end
        @(posedge clk);
        #1;
        spurious_ack = 1'b0;
        model_load(32'h30C, h);
        do_access(1'b0, 32'h30C, 32'h0, 4'h0, -1, rd, cyc, rq);
        total++; if (cyc != 0 || rd !== mem_read(32'h30C)) $display("FAIL post_spurious_hit got cyc=%0d rd=%h exp 0/%h", cyc, rd, mem_read(32'h30C)); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, a; int cyc, rq; bit h;
        for (int i = 0; i < LW; i++) begin
            a = 32'h300 + 32'(4 * i);
            model_load(a, h);
            do_access(1'b0, a, 32'h0, 4'h0, -1, rd, cyc, rq);
            total++; if (cyc != 0 || rd !== mem_read(a)) $display("FAIL b2b_hit[%0d] got cyc=%0d rd=%h exp 0/%h", i, cyc, rd, mem_read(a)); else passed++;
        end
        total++; if (hit_count !== 32'(ref_hits)) $display("FAIL b2b_hits got %0d exp %0d", hit_count, ref_hits); else passed++;
    endtask

    task automatic test_random();
        logic [31:0] rd, a, wd; logic [3:0] st; int cyc, rq; bit h;
        ack_delay = -1;
        for (int n = 0; n < 80; n++) begin
            a = 32'($urandom_range(0, 255)) << 2;
            if ($urandom_range(0, 9) < 3) begin
                wd = $urandom; st = 4'($urandom_range(0, 15));
                do_access(1'b1, a, wd, st, -1, rd, cyc, rq);
                total++;
                if (txq.size() != 1 || txq[0].we !== 1'b1 || txq[0].addr !== a || txq[0].wdata !== wd || txq[0].wstrb !== st || cyc < 1)
                    $display("FAIL rnd_store[%0d] got n=%0d addr=%h data=%h strb=%b cyc=%0d exp addr=%h data=%h strb=%b",
                             n, txq.size(), txq[0].addr, txq[0].wdata, txq[0].wstrb, cyc, a, wd, st);
                else passed++;
            end else begin
                model_load(a, h);
                do_access(1'b0, a, 32'h0, 4'h0, -1, rd, cyc, rq);
                total++;
                if (h ? (cyc != 0 || txq.size() != 0) : (cyc < LW + 1 || txq.size() != LW || txq[0].addr !== (a & ~32'hF)))
                    $display("FAIL rnd_load_kind[%0d] addr=%h got cyc=%0d n=%0d exp hit=%0d", n, a, cyc, txq.size(), h);
                else passed++;
                total++; if (rd !== mem_read(a)) $display("FAIL rnd_rdata[%0d] addr=%h got %h exp %h", n, a, rd, mem_read(a)); else passed++;
            end
        end
        total++; if (hit_count !== 32'(ref_hits)) $display("FAIL rnd_hits got %0d exp %0d", hit_count, ref_hits); else passed++;
        total++; if (miss_count !== 32'(ref_misses)) $display("FAIL rnd_misses got %0d exp %0d", miss_count, ref_misses); else passed++;
    endtask

    initial begin
        core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0; core_wstrb = '0;
        invalidate = 1'b0;
        mem_model[32'h100] = 32'hA0;
        mem_model[32'h104] = 32'hA1;
        mem_model[32'h108] = 32'hA2;
        mem_model[32'h10C] = 32'hA3;
        test_reset();
        test_first_miss();
        test_hit();
        test_store_hit();
        test_store_miss();
        test_conflict();
        test_reset_midfill();
        test_invalidate();
        test_inv_with_req();
        test_spurious_ack();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
